// File: rtl/mult_hilo_if.sv
// mult_hilo_if: decoder/execute-side bundle for the HI/LO multiplier
//   master: decoder/execute stage (drives start, signed_op, op_a, op_b, read_hi, read_lo)
//   slave : mult_hilo (drives hi, lo, busy, done, stall)
interface mult_hilo_if #(parameter int WIDTH = 32);
  logic start, signed_op, read_hi, read_lo, busy, done, stall;
  logic [WIDTH-1:0] op_a, op_b, hi, lo;
  modport master (output start, signed_op, op_a, op_b, read_hi, read_lo,
                  input hi, lo, busy, done, stall);
  modport slave (input start, signed_op, op_a, op_b, read_hi, read_lo,
                 output hi, lo, busy, done, stall);
endinterface

// File: rtl/mult_hilo.sv
// mult_hilo: iterative radix-2 32x32 multiplier owning the HI/LO register pair
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state including HI/LO
//   bus   : slave side of mult_hilo_if
//           in  start, signed_op, op_a, op_b, read_hi, read_lo
//           out hi, lo (registered), busy, done (one-cycle pulse), stall (combinational)
module mult_hilo #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  mult_hilo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] mcand, mplier, hi, lo;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH:0] sum;
  logic [CW-1:0] count;
  logic neg, busy, done;
  // Upper half plus multiplicand keeps its carry so the right shift loses nothing.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign prod = neg ? -acc : acc;
  assign bus.hi = hi;
  assign bus.lo = lo;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.stall = (bus.start | bus.read_hi | bus.read_lo) & busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      count <= '0;
      neg <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          // Magnitudes fit unsigned WIDTH bits, including the most negative value.
          mcand <= (bus.signed_op & bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
          mplier <= (bus.signed_op & bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
          neg <= bus.signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          acc <= '0;
          count <= CW'(WIDTH - 1);
          busy <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          acc <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count <= count - 1'b1;
          if (count == '0) state <= FIX;
        end
        FIX: begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mult_hilo.sv
// tb_mult_hilo: directed and random checks of mult_hilo against a plain-arithmetic product model
module tb_mult_hilo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  mult_hilo_if #(.WIDTH(32)) bus ();
  mult_hilo #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] e;
    if (s) e = longint'($signed(a)) * longint'($signed(b));
    else e = {32'b0, a} * {32'b0, b};
    return e;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic finish_op(input logic [63:0] e, input string tag);
    int n, nb;
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      bus.signed_op = 1'($urandom);
      if (bus.busy) nb++;
    end while (!bus.done && n < 100);
    chk({tag, " latency"}, 64'(n), 64'd34);
    chk({tag, " busy_cycles"}, 64'(nb), 64'd33);
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, " hi"}, 64'(bus.hi), 64'(e[63:32]));
    chk({tag, " lo"}, 64'(bus.lo), 64'(e[31:0]));
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
  endtask
  task automatic mult(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    @(negedge clk);
    bus.op_a = a;
    bus.op_b = b;
    bus.signed_op = s;
    bus.start = 1'b1;
    finish_op(ref_mul(a, b, s), tag);
  endtask
  initial begin
    logic [31:0] a1, b1;
    logic [63:0] e1;
    int n;
    bus.start = 1'b1;
    bus.signed_op = 1'b0;
    bus.op_a = 32'hFFFF_FFFF;
    bus.op_b = 32'hFFFF_FFFF;
    bus.read_hi = 1'b1;
    bus.read_lo = 1'b1;
    #1;
    chk("rst hi", 64'(bus.hi), 64'd0);
    chk("rst lo", 64'(bus.lo), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst stall", 64'(bus.stall), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst held busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    bus.read_hi = 1'b0;
    bus.read_lo = 1'b0;
    rst_n = 1'b1;
    mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_ffxff");
    mult(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, "s_m1x5");
    mult(32'hFFFF_FFFF, 32'h0000_0005, 1'b0, "u_ffx5");
    mult(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minxmin");
    mult(32'h8000_0000, 32'h0000_0001, 1'b1, "s_minx1");
    for (int i = 0; i < 20; i++) mult($urandom, $urandom, 1'($urandom), "rnd");
    a1 = $urandom;
    b1 = $urandom;
    e1 = ref_mul(a1, b1, 1'b1);
    @(negedge clk);
    bus.op_a = a1;
    bus.op_b = b1;
    bus.signed_op = 1'b1;
    bus.start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start = (n == 10);
      if (n == 10) begin
        bus.op_a = 32'd2;
        bus.op_b = 32'd3;
        bus.signed_op = 1'b0;
      end
      bus.read_hi = 1'b1;
      #1 chk("hz stall", 64'(bus.stall), 64'(n < 34));
    end while (!bus.done && n < 100);
    chk("hz latency", 64'(n), 64'd34);
    chk("hz read hi", 64'(bus.hi), 64'(e1[63:32]));
    chk("hz read lo", 64'(bus.lo), 64'(e1[31:0]));
    bus.read_hi = 1'b0;
    bus.op_a = 32'd2;
    bus.op_b = 32'd3;
    bus.signed_op = 1'b0;
    bus.start = 1'b1;
    finish_op(64'd6, "hz second");
    @(negedge clk);
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    bus.signed_op = 1'b1;
    bus.start = 1'b1;
    repeat (11) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("ab busy_before", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ab busy", 64'(bus.busy), 64'd0);
    chk("ab hi", 64'(bus.hi), 64'd0);
    chk("ab lo", 64'(bus.lo), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("ab no_done", 64'(bus.done), 64'd0);
    end
    rst_n = 1'b1;
    mult(32'h1234_5678, 32'h0, 1'b1, "ab zero");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
